// File: rtl/ebr_pkg.sv
// Shared types and constants for the EBR burst reader.
package ebr_pkg;

  localparam int MAX_SKID = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/ebr_reader_fifo.sv
// Small circular FIFO that buffers RAM read data ahead of the output register.
module ebr_reader_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_FIFO = 4,
  localparam int PW = (DEPTH_FIFO > 1) ? $clog2(DEPTH_FIFO) : 1,
  localparam int CW = $clog2(DEPTH_FIFO + 1)
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH_FIFO];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH_FIFO - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wptr_d = push ? nxt(wptr_q) : wptr_q;
    rptr_d = pop  ? nxt(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge gclk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (cnt_q == CW'(DEPTH_FIFO));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/ebr_reader.sv
// Burst reader: turns (addr, len) commands into RAM reads and streams the data out in order.
module ebr_reader
  import ebr_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 1024,
  parameter int MAX_OUTSTANDING = MAX_SKID,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [AW-1:0]    i_cmd_addr,
  input  logic [LW-1:0]    i_cmd_len,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  output logic [AW-1:0]    o_ram_addr,
  output logic             o_ram_addr_valid,
  input  logic             i_ram_addr_ready,
  input  logic [WIDTH-1:0] i_ram_data,
  input  logic             i_ram_valid,
  output logic             o_ram_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  state_e           state_q, state_d;
  logic             rst_sync_q;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic             addr_hs, out_hs, ram_hs, load;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_dout;

  // Release is held back one edge so the command port opens on a clean cycle.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync_q <= 1'b0;
    else            rst_sync_q <= 1'b1;
  end

  assign o_cmd_ready      = (state_q == IDLE) && rst_sync_q;
  assign o_ram_addr_valid = (state_q == ISSUE) && (outst_q != OW'(MAX_OUTSTANDING));
  assign o_ram_ready      = (state_q != IDLE) && !fifo_full;
  assign o_ram_addr       = addr_q;
  assign o_data           = data_q;
  assign o_valid          = valid_q;
  assign o_last           = last_q;
  assign o_busy           = (state_q != IDLE);
  assign o_done           = done_q;

  assign addr_hs = o_ram_addr_valid && i_ram_addr_ready;
  assign out_hs  = valid_q && i_ready;
  assign ram_hs  = i_ram_valid && o_ram_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    len_d     = len_q;
    idx_d     = idx_q;
    outst_d   = outst_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (o_cmd_ready && i_cmd_valid && (i_cmd_len != '0)) begin
          state_d = ISSUE;
          addr_d  = i_cmd_addr;
          rem_d   = i_cmd_len;
          len_d   = i_cmd_len;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        if (addr_hs) begin
          addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
          if (rem_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs && last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register refills from the FIFO head, or straight from the RAM
    // when the FIFO is empty so the first word costs only one cycle.
    if (out_hs) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    load = (!valid_q || i_ready) && (!fifo_empty || ram_hs);
    if (load) begin
      valid_d = 1'b1;
      idx_d   = idx_q + LW'(1);
      last_d  = (idx_q == len_q - LW'(1));
      if (!fifo_empty) begin
        data_d    = fifo_dout;
        fifo_pop  = 1'b1;
        fifo_push = ram_hs;
      end else begin
        data_d    = i_ram_data;
      end
    end else begin
      fifo_push = ram_hs;
    end

    // Words in flight: issued to the RAM but not yet taken by the consumer.
    if (addr_hs && !out_hs)      outst_d = outst_q + OW'(1);
    else if (out_hs && !addr_hs) outst_d = outst_q - OW'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      outst_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      outst_q <= outst_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  ebr_reader_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_FIFO (MAX_OUTSTANDING)
  ) u_fifo (
    .gclk   (i_clock),
    .grst_n (i_reset_n),
    .push   (fifo_push),
    .din    (i_ram_data),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_ebr_reader.sv
// Scoreboard bench for ebr_reader with a RAM model returning data[a] = a[7:0].
module tb_ebr_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LW    = AW + 1;
  localparam int MAXO  = 4;

  logic             i_clock = 1'b0;
  logic             i_reset_n;
  logic [AW-1:0]    i_cmd_addr;
  logic [LW-1:0]    i_cmd_len;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [AW-1:0]    o_ram_addr;
  logic             o_ram_addr_valid;
  logic             i_ram_addr_ready;
  logic [WIDTH-1:0] i_ram_data;
  logic             i_ram_valid;
  logic             o_ram_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_last;
  logic             o_busy;
  logic             o_done;

  always #5 i_clock = ~i_clock;

  ebr_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clock          (i_clock),
    .i_reset_n        (i_reset_n),
    .i_cmd_addr       (i_cmd_addr),
    .i_cmd_len        (i_cmd_len),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .o_ram_addr       (o_ram_addr),
    .o_ram_addr_valid (o_ram_addr_valid),
    .i_ram_addr_ready (i_ram_addr_ready),
    .i_ram_data       (i_ram_data),
    .i_ram_valid      (i_ram_valid),
    .o_ram_ready      (o_ram_ready),
    .o_data           (o_data),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [AW-1:0]  exp_addr_q [$];
  logic [WIDTH:0] exp_data_q [$];
  logic [AW-1:0]  rq [$];
  int outst = 0, addr_hs_cnt = 0, out_hs_cnt = 0, done_cnt = 0;
  int ready_mode = 0;
  bit aready_rand = 1'b0;
  bit spur = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT handshake with empty scoreboard", name);
  endtask

  // Monitor: values are stable at the falling edge, so a valid&ready seen here
  // completes at the next rising edge.
  logic [WIDTH:0] mon_e;
  always @(negedge i_clock) begin
    if (o_ram_addr_valid && i_ram_addr_ready) begin
      addr_hs_cnt++;
      outst++;
      chk("outstanding_le_max", 32'(outst <= MAXO), 1);
      if (exp_addr_q.size() == 0) unexpected("ram_addr");
      else chk("ram_addr", 32'(o_ram_addr), 32'(exp_addr_q.pop_front()));
    end
    if (o_valid && i_ready) begin
      out_hs_cnt++;
      outst--;
      if (exp_data_q.size() == 0) unexpected("o_data");
      else begin
        mon_e = exp_data_q.pop_front();
        chk("o_data", 32'(o_data), 32'(mon_e[WIDTH-1:0]));
        chk("o_last", 32'(o_last), 32'(mon_e[WIDTH]));
      end
    end
    if (o_done) done_cnt++;
  end

  // RAM model: one-cycle read latency, responses held until accepted.
  initial begin
    logic          a_hs, d_hs;
    logic [AW-1:0] a, head;
    i_ram_valid = 1'b0;
    i_ram_data = '0;
    i_ram_addr_ready = 1'b0;
    forever begin
      @(negedge i_clock);
      a_hs = o_ram_addr_valid && i_ram_addr_ready;
      a    = o_ram_addr;
      d_hs = i_ram_valid && o_ram_ready;
      @(posedge i_clock);
      #1;
      if (!i_reset_n) rq.delete();
      else begin
        if (d_hs && rq.size() > 0) void'(rq.pop_front());
        if (a_hs) rq.push_back(a);
      end
      i_ram_addr_ready = aready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rq.size() > 0) begin
        head = rq[0];
        i_ram_valid = 1'b1;
        i_ram_data = head[WIDTH-1:0];
      end else if (spur) begin
        i_ram_valid = 1'b1;
        i_ram_data = 8'hA5;
      end else begin
        i_ram_valid = 1'b0;
      end
    end
  end

  // Consumer ready: 0 = always, 1 = stalled, 2 = toggling.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clock);
      #1;
      case (ready_mode)
        1:       i_ready = 1'b0;
        2:       i_ready = ~i_ready;
        default: i_ready = 1'b1;
      endcase
    end
  end

  task automatic send_cmd(input int addr, input int len);
    int  a;
    bit  acc;
    for (int i = 0; i < len; i++) begin
      a = (addr + i) % DEPTH;
      exp_addr_q.push_back(AW'(a));
      exp_data_q.push_back({(i == len - 1), 8'(a)});
    end
    @(posedge i_clock);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_addr  = AW'(addr);
    i_cmd_len   = LW'(len);
    acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge i_clock);
      acc = o_cmd_ready;
    end
    chk("cmd_accept", 32'(acc), 1);
    @(posedge i_clock);
    #1;
    i_cmd_valid = 1'b0;
    @(negedge i_clock);
    if (len > 0) begin
      chk("addr_valid_first", 32'(o_ram_addr_valid), 1);
      chk("addr_first", 32'(o_ram_addr), 32'(addr));
      chk("busy_in_burst", 32'(o_busy), 1);
    end else begin
      chk("len0_no_addr", 32'(o_ram_addr_valid), 0);
      chk("len0_cmd_ready_next", 32'(o_cmd_ready), 1);
      chk("len0_not_busy", 32'(o_busy), 0);
    end
  endtask

  task automatic wait_done(input string name);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge i_clock);
      #1;
      seen = (done_cnt > d0);
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
    repeat (3) @(posedge i_clock);
    #1;
    chk({name, "_single_done"}, 32'(done_cnt - d0), 1);
    chk({name, "_all_words"}, 32'(exp_data_q.size()), 0);
    chk({name, "_idle"}, 32'(o_busy), 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_cmd_ready"}, 32'(o_cmd_ready), 0);
    chk({name, "_addr_valid"}, 32'(o_ram_addr_valid), 0);
    chk({name, "_ram_ready"}, 32'(o_ram_ready), 0);
    chk({name, "_valid"}, 32'(o_valid), 0);
    chk({name, "_last"}, 32'(o_last), 0);
    chk({name, "_busy"}, 32'(o_busy), 0);
    chk({name, "_done"}, 32'(o_done), 0);
    chk({name, "_ram_addr"}, 32'(o_ram_addr), 0);
    chk({name, "_data"}, 32'(o_data), 0);
  endtask

  initial begin
    int d0, h0, o0;
    i_reset_n   = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_len   = '0;
    #1 i_reset_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    @(negedge i_clock);
    chk("cmd_ready_before_sync", 32'(o_cmd_ready), 0);
    @(negedge i_clock);
    chk("cmd_ready_after_sync", 32'(o_cmd_ready), 1);

    // Basic burst with first-word latency
    send_cmd(10, 5);
    @(negedge i_clock);
    chk("latency_no_valid_yet", 32'(o_valid), 0);
    @(negedge i_clock);
    chk("latency_first_valid", 32'(o_valid), 1);
    chk("latency_first_data", 32'(o_data), 10);
    wait_done("basic");

    // Stray RAM data while idle must be refused
    spur = 1'b1;
    repeat (4) @(negedge i_clock);
    chk("idle_ram_ready", 32'(o_ram_ready), 0);
    spur = 1'b0;
    repeat (2) @(posedge i_clock);

    // Address wrap at top of RAM
    send_cmd(1022, 4);
    wait_done("wrap");

    // Zero-length command is discarded
    d0 = done_cnt;
    send_cmd(5, 0);
    send_cmd(20, 3);
    chk("len0_no_done", 32'(done_cnt - d0), 0);
    wait_done("after_len0");

    // Consumer stall: only MAXO reads may be in flight
    ready_mode = 1;
    repeat (2) @(posedge i_clock);
    h0 = addr_hs_cnt;
    send_cmd(200, 8);
    repeat (20) @(posedge i_clock);
    #1;
    chk("stall_addr_hs", 32'(addr_hs_cnt - h0), 4);
    chk("stall_addr_valid_low", 32'(o_ram_addr_valid), 0);
    ready_mode = 0;
    wait_done("stall");

    // Toggling consumer, random RAM address ready
    ready_mode = 2;
    aready_rand = 1'b1;
    send_cmd(500, 16);
    wait_done("toggle");
    ready_mode = 0;
    aready_rand = 1'b0;
    repeat (2) @(posedge i_clock);

    // Reset in the middle of a burst
    o0 = out_hs_cnt;
    send_cmd(300, 8);
    for (int c = 0; c < 100 && (out_hs_cnt - o0) < 3; c++) begin
      @(posedge i_clock);
      #1;
    end
    chk("midreset_reached_3", 32'((out_hs_cnt - o0) >= 3), 1);
    #2 i_reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    exp_addr_q.delete();
    exp_data_q.delete();
    outst = 0;
    d0 = done_cnt;
    repeat (4) @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    @(negedge i_clock);
    chk("rerelease_cmd_ready_low", 32'(o_cmd_ready), 0);
    @(negedge i_clock);
    chk("rerelease_cmd_ready_high", 32'(o_cmd_ready), 1);
    chk("midreset_no_done", 32'(done_cnt - d0), 0);
    send_cmd(40, 2);
    wait_done("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ebr_reader.md
EBR_READER -- requirements
Module: ebr_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits, SHALL match the attached RAM.
REQ-002 Parameter DEPTH, default 1024, RAM depth in words; AW = $clog2(DEPTH).
REQ-003 Parameter MAX_OUTSTANDING, default 4, maximum read addresses in flight.
REQ-004 i_clock  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-005 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_cmd_addr  in  AW  start address of a burst.
REQ-007 i_cmd_len  in  AW+1  burst length in words, 0..DEPTH.
REQ-008 i_cmd_valid / o_cmd_ready  in/out  1  command handshake.
REQ-009 o_ram_addr  out  AW  read address to the RAM.
REQ-010 o_ram_addr_valid / i_ram_addr_ready  out/in  1  RAM address handshake.
REQ-011 i_ram_data  in  WIDTH  read data from the RAM.
REQ-012 i_ram_valid / o_ram_ready  in/out  1  RAM data handshake.
REQ-013 o_data  out  WIDTH  output stream word.
REQ-014 o_valid / i_ready  out/in  1  output stream handshake.
REQ-015 o_last  out  1  high with the final word of a burst.
REQ-016 o_busy  out  1  high while a burst is active.
REQ-017 o_done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-018 Any handshake SHALL complete on a cycle where valid and ready are both high; a valid SHALL NOT drop or change payload until accepted.
REQ-019 FSM states: IDLE, ISSUE, DRAIN. In IDLE o_cmd_ready SHALL be 1; in all other states it SHALL be 0.
REQ-020 IDLE: command accepted with len 0 SHALL be discarded, with no RAM access and no o_done; len >= 1 SHALL go to ISSUE.
REQ-021 ISSUE: o_ram_addr_valid SHALL be high on the cycle after command acceptance, with o_ram_addr = i_cmd_addr.
REQ-022 On each address handshake, the address SHALL increment by 1 modulo DEPTH (DEPTH-1 wraps to 0).
REQ-023 Addresses issued SHALL equal len exactly. After the last address handshake, the state SHALL be DRAIN.
REQ-024 o_ram_addr_valid SHALL be 0 whenever the outstanding count equals MAX_OUTSTANDING.
REQ-025 Outstanding count: +1 on an address handshake, -1 on an output handshake, unchanged if both occur in the same cycle; range 0..MAX_OUTSTANDING.
REQ-026 RAM data SHALL enter an internal FIFO of MAX_OUTSTANDING entries. o_ram_ready SHALL be the FIFO's not-full flag.
REQ-027 o_data/o_valid SHALL come from the FIFO head and be registered. First word latency: o_valid high on the cycle after the i_ram_valid handshake.
REQ-028 Word order at the output SHALL equal address order.
REQ-029 o_last SHALL be high exactly with output word index len-1.
REQ-030 DRAIN: on the o_last handshake, o_done SHALL pulse on the next cycle and the state SHALL return to IDLE. A new command SHALL be accepted no earlier than that cycle.
REQ-031 o_busy SHALL be high in ISSUE and DRAIN and low in IDLE.
REQ-032 len = DEPTH SHALL read every location once, wrapping through 0.
REQ-033 i_ram_valid in IDLE SHALL be ignored and SHALL NOT be written to the FIFO.

Reset
REQ-034 Reset assertion SHALL take effect immediately, independent of i_clock.
REQ-035 While in reset: state IDLE, counters 0, FIFO empty. Outputs: o_cmd_ready 0, o_ram_addr_valid 0, o_ram_ready 0, o_valid 0, o_last 0, o_busy 0, o_done 0, o_ram_addr 0, o_data 0.
REQ-036 Reset release SHALL be synchronised internally; o_cmd_ready SHALL rise the first cycle after release.
REQ-037 Reset during a burst SHALL abandon it silently (no o_done); the attached RAM SHALL be reset in the same cycle.

Structure
REQ-038 Package ebr_pkg SHALL hold the FSM state enum typedef and the MAX_SKID = 4 constant. MAX_OUTSTANDING SHALL default to MAX_SKID.
REQ-039 The FIFO SHALL be one sub-module, ebr_reader_fifo (parameters WIDTH, DEPTH_FIFO; with push/pop/full/empty); all other logic SHALL stay flat.

Verification
REQ-040 Command addr 10, len 5, i_ready held 1, RAM preloaded with data[a] = a -> addresses 10..14, o_data 10..14, o_last with 14, a single o_done.
REQ-041 Command addr 1022, len 4, DEPTH 1024 -> addresses 1022, 1023, 0, 1; output order preserved.
REQ-042 len 8 with i_ready 0 for 20 cycles -> exactly 4 address handshakes, then stall. Releasing i_ready yields all 8 words in order with no loss.
REQ-043 len 0 command -> no o_ram_addr_valid, no o_done; next command is accepted the following cycle.
REQ-044 i_ready toggling 1010..., i_ram_addr_ready random, len 16 -> 16 words in order, outstanding never above 4.
REQ-045 i_reset_n low mid-burst (after 3 of 8 words) -> all outputs 0 within the same cycle; a new len 2 burst after release completes correctly.
